// File: rtl/iic_pkg.sv
// Shared types and widths for the IIC arbiter: FSM encoding, field widths,
// default start-watchdog limit.
package iic_pkg;

    localparam int SADDR_W            = 16;
    localparam int BYTE_W             = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/iic_arbiter_rr_pick.sv
// Combinational round-robin selector: first pending index after last_grant,
// wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_pending,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_vld
);

    logic [IDX_W-1:0] w_idx;

    // Scan farthest-to-nearest so the closest candidate after last_grant wins.
    always_comb begin
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
            if (i_pending[w_idx]) begin
                o_grant_idx = w_idx;
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// Round-robin arbiter sharing one iic_master among NUM_REQ requesters.
// Optional start watchdog in WAIT_BUSY enabled by IIC_ARB_TIMEOUT_EN.
module iic_arbiter
    import iic_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_slave_addr_ex,
    input  logic [SADDR_W*NUM_REQ-1:0] req_slave_addr,
    input  logic [NUM_REQ-1:0]         req_rw,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_reg_addr,
    input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_brust_vaild,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_brust_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [BYTE_W-1:0]          req_rdata,
    output logic [NUM_REQ-1:0]         req_err,
    output logic                       slave_addr_ex,
    output logic [SADDR_W-1:0]         slave_addr,
    output logic                       send_rw,
    output logic [BYTE_W-1:0]          reg_addr,
    output logic [BYTE_W-1:0]          send_data,
    output logic                       send_en,
    output logic                       brust_vaild,
    input  logic                       send_busy,
    input  logic                       brust_ready,
    input  logic [BYTE_W-1:0]          recv_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("iic_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_last;
    logic               r_busy;

    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic               w_take;
    logic               w_granted;
    logic               w_done;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_clr;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_pending   (r_pending),
        .i_last_grant(r_last),
        .o_grant_idx (w_pick_idx),
        .o_grant_vld (w_pick_vld)
    );

    assign w_take     = (r_state == ST_IDLE) && w_pick_vld;
    assign w_clr      = w_take ? (ONE << w_pick_idx) : '0;
    assign w_granted  = (r_state != ST_IDLE);
    assign w_done     = (r_state == ST_DONE);
    assign w_owner_oh = ONE << r_owner;

    // A new pulse in the same cycle as the grant-clear must survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | req_valid;
    end

`ifdef IIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
`endif

    // Busy is sampled through one register, so completion lands two cycles
    // after the master drops busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_busy  <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_busy <= send_busy;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_owner <= w_pick_idx;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef IIC_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
`endif
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (r_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
`ifdef IIC_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!r_busy) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_last  <= r_owner;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_grant       = w_granted ? w_owner_oh : '0;
    assign req_done        = w_done ? w_owner_oh : '0;
    assign req_rdata       = w_done ? recv_data : '0;
    assign req_brust_ready = (w_granted && brust_ready) ? w_owner_oh : '0;
    assign send_en         = (r_state == ST_ISSUE);

`ifdef IIC_ARB_TIMEOUT_EN
    assign req_err = (w_done && r_err) ? w_owner_oh : '0;
`else
    assign req_err = '0;
`endif

    assign slave_addr_ex = w_granted & req_slave_addr_ex[r_owner];
    assign send_rw       = w_granted & req_rw[r_owner];
    assign brust_vaild   = w_granted & req_brust_vaild[r_owner];
    assign slave_addr    = w_granted ? req_slave_addr[int'(r_owner)*SADDR_W +: SADDR_W] : '0;
    assign reg_addr      = w_granted ? req_reg_addr[int'(r_owner)*BYTE_W +: BYTE_W] : '0;
    assign send_data     = w_granted ? req_data[int'(r_owner)*BYTE_W +: BYTE_W] : '0;

endmodule

// File: tb/tb_iic_arbiter.sv
// Scoreboard bench for iic_arbiter with a behavioural iic_master model.
// Define IIC_ARB_TIMEOUT_EN to also run the start-watchdog scenario.
module tb_iic_arbiter;
    import iic_pkg::*;

    localparam int N = 2;
`ifdef IIC_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic              clk, rst_n;
    logic [N-1:0]      req_valid, req_slave_addr_ex, req_rw, req_brust_vaild;
    logic [16*N-1:0]   req_slave_addr;
    logic [8*N-1:0]    req_reg_addr, req_data;
    logic [N-1:0]      req_grant, req_brust_ready, req_done, req_err;
    logic [7:0]        req_rdata;
    logic              slave_addr_ex, send_rw, send_en, brust_vaild;
    logic [15:0]       slave_addr;
    logic [7:0]        reg_addr, send_data;
    logic              send_busy, brust_ready;
    logic [7:0]        recv_data;

    iic_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_slave_addr_ex(req_slave_addr_ex),
        .req_slave_addr(req_slave_addr), .req_rw(req_rw),
        .req_reg_addr(req_reg_addr), .req_data(req_data),
        .req_brust_vaild(req_brust_vaild), .req_grant(req_grant),
        .req_brust_ready(req_brust_ready), .req_done(req_done),
        .req_rdata(req_rdata), .req_err(req_err),
        .slave_addr_ex(slave_addr_ex), .slave_addr(slave_addr),
        .send_rw(send_rw), .reg_addr(reg_addr), .send_data(send_data),
        .send_en(send_en), .brust_vaild(brust_vaild),
        .send_busy(send_busy), .brust_ready(brust_ready), .recv_data(recv_data)
    );

    typedef struct packed {
        logic [N-1:0] oh;
        logic         rw;
        logic [15:0]  addr;
        logic [7:0]   rg;
        logic [7:0]   data;
    } iss_t;
    typedef struct packed {
        logic [N-1:0] oh;
        logic [7:0]   rdata;
    } done_t;

    iss_t  q_iss[$];
    done_t q_done[$];
    iss_t  m_e;
    done_t m_d;
    int    total = 0, bad = 0, cyc = 0;

    // Master model: busy for m_len cycles after send_en; burst strobes every 4th.
    int         m_len = 20, m_cnt;
    logic       m_burst = 1'b0, m_never = 1'b0;
    logic [7:0] m_rdata = 8'hC3;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    m_cnt <= 0;
        else if (send_en && !m_never)  m_cnt <= m_len;
        else if (m_cnt != 0)           m_cnt <= m_cnt - 1;
    end
    assign send_busy   = (m_cnt != 0);
    assign brust_ready = m_burst && (m_cnt != 0) && (m_cnt % 4 == 1);
    assign recv_data   = m_rdata;

    // Scoreboard monitor: every issue and completion must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (send_en) begin
                total++;
                if (q_iss.size() == 0) begin
                    bad++; $display("FAIL unexpected_send_en cyc=%0d grant=%b", cyc, req_grant);
                end else begin
                    m_e = q_iss.pop_front();
                    if ({req_grant, send_rw, slave_addr, reg_addr, send_data} !== m_e) begin
                        bad++;
                        $display("FAIL issue_fields got=%h exp=%h", {req_grant, send_rw, slave_addr, reg_addr, send_data}, m_e);
                    end
                end
            end
            if (req_done != '0) begin
                total++;
                if (q_done.size() == 0) begin
                    bad++; $display("FAIL unexpected_done cyc=%0d done=%b", cyc, req_done);
                end else begin
                    m_d = q_done.pop_front();
                    if ({req_done, req_rdata} !== m_d) begin
                        bad++; $display("FAIL done_fields got=%h exp=%h", {req_done, req_rdata}, m_d);
                    end
                end
            end
            if ($countones(req_grant) > 1) begin
                total++; bad++; $display("FAIL grant_overlap got=%b exp=onehot", req_grant);
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [15:0] a,
                           input logic [7:0] r, input logic [7:0] d);
        req_rw[i] = rw;
        req_slave_addr[16*i +: 16] = a;
        req_reg_addr[8*i +: 8] = r;
        req_data[8*i +: 8] = d;
    endtask

    task automatic push_tx(input int i, input logic [7:0] rd);
        logic [N-1:0] oh;
        oh = '0;
        oh[i] = 1'b1;
        q_iss.push_back({oh, req_rw[i], req_slave_addr[16*i +: 16], req_reg_addr[8*i +: 8], req_data[8*i +: 8]});
        q_done.push_back({oh, rd});
    endtask

    task automatic pulse(input logic [N-1:0] m, output int t);
        @(posedge clk); #1;
        req_valid = m;
        t = cyc;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    // kind 0: send_en, 1: any req_done, 2: send_busy falling. at=-1 on timeout.
    task automatic wait_ev(input int kind, input int lim, output int at);
        logic prev;
        at = -1;
        prev = send_busy;
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if ((kind == 0 && send_en) || (kind == 1 && req_done != '0) ||
                (kind == 2 && prev && !send_busy)) begin
                at = cyc;
                break;
            end
            prev = send_busy;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        q_iss.delete();
        q_done.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_slave_addr_ex = '0; req_rw = '0; req_brust_vaild = '0;
        req_slave_addr = '0; req_reg_addr = '0; req_data = '0;
        #3;
        total++;
        if ({req_grant, req_done, req_brust_ready, req_err, req_rdata} !== '0) begin
            bad++; $display("FAIL reset_req_side got=%h exp=0", {req_grant, req_done, req_brust_ready, req_err, req_rdata});
        end
        total++;
        if ({slave_addr_ex, slave_addr, send_rw, reg_addr, send_data, send_en, brust_vaild} !== '0) begin
            bad++; $display("FAIL reset_master_side got=%h exp=0", {slave_addr_ex, slave_addr, send_rw, reg_addr, send_data, send_en, brust_vaild});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({req_grant, send_en, req_done} !== '0) begin
            bad++; $display("FAIL idle_after_reset got=%h exp=0", {req_grant, send_en, req_done});
        end
    endtask

    task automatic test_single_write();
        int t, ts, d, dn;
        m_len = 20; m_rdata = 8'hC3;
        set_req(0, 1'b0, 16'h0078, 8'h00, 8'hAE);
        push_tx(0, 8'hC3);
        pulse(2'b01, t);
        wait_ev(0, 10, ts);
        total++;
        if (ts !== t + 2) begin bad++; $display("FAIL write_issue_latency got=%0d exp=%0d", ts, t + 2); end
        wait_ev(2, 40, d);
        wait_ev(1, 10, dn);
        total++;
        if (d < 0 || dn !== d + 2) begin bad++; $display("FAIL write_done_latency got=%0d exp=%0d", dn, d + 2); end
        @(posedge clk);
        total++;
        if (q_iss.size() + q_done.size() != 0) begin bad++; $display("FAIL write_leftover got=%0d exp=0", q_iss.size() + q_done.size()); end
    endtask

    task automatic test_contention();
        int t, ts, d, dn, ts2;
        do_reset();
        set_req(0, 1'b0, 16'h0078, 8'h01, 8'h11);
        set_req(1, 1'b0, 16'h003C, 8'h10, 8'h55);
        push_tx(0, 8'hC3);
        push_tx(1, 8'hC3);
        pulse(2'b11, t);
        wait_ev(0, 10, ts);
        total++;
        if (ts !== t + 2) begin bad++; $display("FAIL cont_first_issue got=%0d exp=%0d", ts, t + 2); end
        wait_ev(2, 40, d);
        wait_ev(1, 10, dn);
        wait_ev(0, 10, ts2);
        total++;
        if (d < 0 || ts2 !== d + 4) begin bad++; $display("FAIL cont_next_issue got=%0d exp=%0d", ts2, d + 4); end
        wait_ev(1, 40, dn);
        @(posedge clk);
        total++;
        if (dn < 0 || q_iss.size() + q_done.size() != 0) begin bad++; $display("FAIL cont_leftover got=%0d exp=0", q_iss.size() + q_done.size()); end
    endtask

    task automatic test_back_to_back();
        int t, ts, d, dn, ts2;
        set_req(0, 1'b0, 16'h0078, 8'h02, 8'h22);
        push_tx(0, 8'hC3);
        push_tx(0, 8'hC3);
        pulse(2'b01, t);
        wait_ev(0, 10, ts);
        pulse(2'b01, t);  // re-request while already owner
        wait_ev(2, 40, d);
        wait_ev(1, 10, dn);
        wait_ev(0, 10, ts2);
        total++;
        if (d < 0 || ts2 !== d + 4) begin bad++; $display("FAIL b2b_requeue got=%0d exp=%0d", ts2, d + 4); end
        wait_ev(1, 40, dn);
        @(posedge clk);
        total++;
        if (dn < 0 || q_iss.size() + q_done.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", q_iss.size() + q_done.size()); end
    endtask

    task automatic test_fairness();
        int t, dn, n;
        logic [N-1:0] who;
        do_reset();
        m_len = 6;
        for (int k = 0; k < 8; k++) push_tx(k % 2, 8'hC3);
        pulse(2'b11, t);
        n = 0;
        while (n < 8) begin
            wait_ev(1, 60, dn);
            if (dn < 0) begin
                total++; bad++; $display("FAIL fair_timeout got=%0d exp=8", n);
                break;
            end
            n++;
            who = req_done;
            if (n <= 6) pulse(who, t);
        end
        @(posedge clk);
        total++;
        if (q_iss.size() + q_done.size() != 0) begin bad++; $display("FAIL fair_leftover got=%0d exp=0", q_iss.size() + q_done.size()); end
    endtask

    task automatic test_read();
        int t, dn;
        m_len = 10; m_rdata = 8'h5A;
        set_req(1, 1'b1, 16'h0050, 8'h20, 8'h00);
        push_tx(1, 8'h5A);
        pulse(2'b10, t);
        wait_ev(1, 40, dn);
        total++;
        if ({req_done, req_rdata} !== {2'b10, 8'h5A}) begin
            bad++; $display("FAIL read_data got=%h exp=%h", {req_done, req_rdata}, {2'b10, 8'h5A});
        end
        @(posedge clk);
        m_rdata = 8'hC3;
    endtask

    task automatic test_burst();
        int t, strobes, k;
        m_len = 16; m_burst = 1'b1;
        req_brust_vaild = 2'b01;
        set_req(0, 1'b0, 16'h0078, 8'h40, 8'h01);
        set_req(1, 1'b0, 16'h003C, 8'h11, 8'h99);
        push_tx(0, 8'hC3);
        push_tx(1, 8'hC3);
        pulse(2'b01, t);
        pulse(2'b10, t);
        strobes = 0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_grant == 2'b01) begin
                total++;
                if ({req_brust_ready[1], brust_vaild, send_data} !== {1'b0, 1'b1, req_data[7:0]}) begin
                    bad++; $display("FAIL burst_route got=%h exp=%h", {req_brust_ready[1], brust_vaild, send_data}, {1'b0, 1'b1, req_data[7:0]});
                end
                if (req_brust_ready[0]) begin
                    strobes++;
                    req_data[7:0] = req_data[7:0] + 8'h11;
                end
            end
            if (req_done[0]) break;
        end
        total++;
        if (strobes !== 4) begin bad++; $display("FAIL burst_strobes got=%0d exp=4", strobes); end
        req_brust_vaild = '0; m_burst = 1'b0;
        wait_ev(1, 60, t);
        @(posedge clk);
        total++;
        if (t < 0 || q_iss.size() + q_done.size() != 0) begin bad++; $display("FAIL burst_leftover got=%0d exp=0", q_iss.size() + q_done.size()); end
    endtask

`ifdef IIC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int t, ts, dn;
        m_never = 1'b1;
        set_req(0, 1'b0, 16'h0078, 8'h00, 8'h00);
        push_tx(0, 8'hC3);
        pulse(2'b01, t);
        wait_ev(0, 10, ts);
        wait_ev(1, 40, dn);
        total++;
        if (dn !== ts + 17 || req_err !== 2'b01) begin
            bad++; $display("FAIL timeout_err got=%0d/%b exp=%0d/01", dn, req_err, ts + 17);
        end
        m_never = 1'b0;
        @(posedge clk);
    endtask
`endif

    task automatic test_reset_mid();
        int t, ts, seen;
        m_len = 20;
        set_req(0, 1'b0, 16'h0078, 8'h03, 8'h33);
        push_tx(0, 8'hC3);
        pulse(2'b01, t);
        wait_ev(0, 10, ts);
        pulse(2'b10, t);  // lost to the reset below
        repeat (8) @(negedge clk);
        total++;
        if (req_grant !== 2'b01) begin bad++; $display("FAIL mid_pre_grant got=%b exp=01", req_grant); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({req_grant, req_done, req_brust_ready, req_rdata, req_err, slave_addr_ex, slave_addr,
             send_rw, reg_addr, send_data, send_en, brust_vaild} !== '0) begin
            bad++; $display("FAIL mid_reset_outputs got=%h exp=0", {req_grant, slave_addr, reg_addr, send_data});
        end
        q_iss.delete();
        q_done.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (send_en || req_grant != '0) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL mid_pending_lost got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_back_to_back();
        test_fairness();
        test_read();
        test_burst();
`ifdef IIC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d exp=finish", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
